memwb_skid_stage: RTL

- Parametrised MEM/WB pipeline stage sitting between the memory-access stage and the register-file write port.
- Registered, with a valid/ready handshake and a 2-entry skid buffer, so MEM can be back-pressured by WB without a combinational ready path.
- Resolves the write-back source (memory read data vs ALU result) at capture and suppresses writes to register x0.
- Provides a bubble-inserting flush and a retired-instruction counter.

---
 rtl/memwb_skid_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/memwb_skid_stage.sv
// -----------------------------------------------------------------------------
// memwb_skid_stage
//
// MEM/WB pipeline register with a valid/ready handshake and a one-entry skid
// register. The MEM stage can be back-pressured by write-back without any
// combinational path from out_ready_i to in_ready_o. The write-back source is
// resolved at capture time, so only {regwrite, rd, data} is stored. Writes to
// x0 are turned into non-writing entries that still flow through the stage.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), async active-high reset
//   in_valid_i        MEM stage presents an instruction
//   in_ready_o        stage can accept this cycle (registered)
//   WB_i              instruction writes the register file
//   WBSrc_i           1 = MemRdata_i, 0 = ALUres_i
//   MemRdata_i        data-memory read data
//   ALUres_i          ALU result
//   rd_addr_i         destination register
//   flush_i           drop all held and incoming instructions (synchronous)
//   out_valid_o       write-back entry valid
//   out_ready_i       write-back consumes the entry
//   RegWrite_o        write enable of the entry (0 for rd = 0 or no entry)
//   rd_addr_o         destination register of the entry
//   wb_data_o         selected write-back data
//   retire_cnt_o      number of consumed entries, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module memwb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              WB_i,
  input  logic              WBSrc_i,
  input  logic [DATA_W-1:0] MemRdata_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Current state
  logic       main_valid, skid_valid, ready_q;
  entry_t     main_q, skid_q;
  logic [CNT_W-1:0] cnt_q;

  // Next state
  logic       main_valid_n, skid_valid_n;
  entry_t     main_n, skid_n;

  entry_t     cap;
  logic       accept, fire;

  // Entry formed from the MEM-stage inputs; raw source operands are not kept.
  always_comb begin
    cap.we   = WB_i & (rd_addr_i != '0);
    cap.rd   = rd_addr_i;
    cap.data = WBSrc_i ? MemRdata_i : ALUres_i;
  end

  assign accept = in_valid_i & ready_q;
  assign fire   = main_valid & out_ready_i;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_n       = main_q;
    skid_n       = skid_q;

    if (flush_i) begin
      // Bubble insertion: anything held or accepted this cycle is dropped.
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!main_valid) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        main_valid_n = 1'b1;
        main_n       = cap;
      end
    end else if (fire) begin
      if (skid_valid) begin
        main_n       = skid_q;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_n       = cap;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_n       = cap;
      skid_valid_n = 1'b1;
    end

    // RegWrite_o comes straight from main_q.we, so it must be cleared
    // whenever main goes empty (stale rd/data are harmless).
    if (!main_valid_n) main_n.we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      // Ready is its own flop so it has no combinational path from outputs.
      ready_q    <= ~skid_valid_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      // Consumption counts even when a flush lands in the same cycle.
      if (fire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready_o   = ready_q;
  assign out_valid_o  = main_valid;
  assign RegWrite_o   = main_q.we;
  assign rd_addr_o    = main_q.rd;
  assign wb_data_o    = main_q.data;
  assign retire_cnt_o = cnt_q;

endmodule
